// File: rtl/ping_pong_tick_counter_pkg.sv
// counter_pkg: shared constants for the ping-pong tick counter slice.
//   DIR_UP / DIR_DOWN : encoding of the direction register and output.
//   DEFAULT_WIDTH     : default counter and bound width.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/ping_pong_tick_counter_if.sv
// ping_pong_tick_counter_if: signal bundle between the counter and its
// driver/consumer.
//   dclk, enable, flip, max, min : driven by the master (control side).
//   tick, direction, out         : driven by the slave (the counter).
//
// Handshake: there is no back-pressure. tick is a one-cycle strobe that
// marks a detected dclk rising edge. out and direction are registered and
// take their post-step values on the clk edge that ends the tick cycle.
// enable, min and max only have an effect during a tick cycle; flip is
// sampled every cycle and remembered until the next step.
interface ping_pong_tick_counter_if #(
  parameter int WIDTH = counter_pkg::DEFAULT_WIDTH
) ();

  logic             dclk;
  logic             enable;
  logic             flip;
  logic [WIDTH-1:0] max;
  logic [WIDTH-1:0] min;
  logic             tick;
  logic             direction;
  logic [WIDTH-1:0] out;

  modport master (
    output dclk, enable, flip, max, min,
    input  tick, direction, out
  );

  modport slave (
    input  dclk, enable, flip, max, min,
    output tick, direction, out
  );

endinterface

// File: rtl/ping_pong_tick_counter_tick_sync.sv
// tick_sync: brings an asynchronous, slow square wave into the clk domain
// and emits a one-cycle pulse for each of its rising edges.
//   clk        : system clock.
//   rst        : asynchronous active-high reset.
//   din        : asynchronous input (e.g. the divided clock).
//   rise_pulse : high for one clk cycle per rising edge of din.
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // sync_q[0] is the metastability-catching stage; the last stage is the
  // first one that is safe to use, and hist_q delays it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ping_pong_tick_counter.sv
// ping_pong_tick_counter: counter that bounces between min and max, moving
// one step per rising edge of dclk (sampled as data in the clk domain).
//   clk : system clock, all state updates on its rising edge.
//   rst : asynchronous active-high reset.
//   bus : slave side of ping_pong_tick_counter_if
//         (dclk, enable, flip, max, min in; tick, direction, out out).
module ping_pong_tick_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  ping_pong_tick_counter_if.slave  bus
);

  logic             tick;
  logic [WIDTH-1:0] out_q;
  logic             dir_q;
  logic             flip_pending_q;

  logic             step;
  logic             eff_dir;
  logic [WIDTH-1:0] next_out;

  tick_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick_sync (
    .clk        (clk),
    .rst        (rst),
    .din        (bus.dclk),
    .rise_pulse (tick)
  );

  // A step needs a valid window (max strictly above min) that also contains
  // the current value; otherwise the counter freezes until the bounds move.
  always_comb begin
    step     = 1'b0;
    eff_dir  = dir_q;
    next_out = out_q;

    step = tick & bus.enable & (bus.max > bus.min) &
           (out_q >= bus.min) & (out_q <= bus.max);

    // A flip arriving in the step cycle itself counts, hence the OR.
    if (flip_pending_q | bus.flip) begin
      eff_dir = ~dir_q;
    end
    // Bounce at the bounds, after the flip has been taken into account.
    if (eff_dir == DIR_UP && out_q == bus.max) begin
      eff_dir = DIR_DOWN;
    end else if (eff_dir == DIR_DOWN && out_q == bus.min) begin
      eff_dir = DIR_UP;
    end

    next_out = (eff_dir == DIR_UP) ? out_q + 1'b1 : out_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q          <= '0;
      dir_q          <= DIR_UP;
      flip_pending_q <= 1'b0;
    end else if (step) begin
      out_q          <= next_out;
      dir_q          <= eff_dir;
      flip_pending_q <= 1'b0;
    end else if (bus.flip) begin
      flip_pending_q <= 1'b1;
    end
  end

  assign bus.tick      = tick;
  assign bus.direction = dir_q;
  assign bus.out       = out_q;

endmodule

// File: tb/tb_ping_pong_tick_counter.sv
// tb_ping_pong_tick_counter: directed bench for ping_pong_tick_counter.
// Each dclk pulse queues the hand-computed {direction, out} expected after
// its step; a monitor pops and compares one entry per observed tick.
module tb_ping_pong_tick_counter;

  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 1;

  logic clk;
  logic rst;

  ping_pong_tick_counter_if #(.WIDTH(WIDTH)) bus ();

  ping_pong_tick_counter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic pend_cmp = 1'b0;

  always @(negedge clk) begin
    if (bus.tick === 1'b1) begin
      // tick must never be high on two consecutive samples
      check("tick_width", {{(W-1){1'b0}}, pend_cmp}, '0);
    end
    if (pend_cmp) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick: actual={dir,out}=0x%0h expected=no tick at %0t",
                 {bus.direction, bus.out}, $time);
      end else begin
        check("step_result", {bus.direction, bus.out}, exp_q.pop_front());
      end
    end
    pend_cmp <= (bus.tick === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse(input int h, input logic dir, input logic [WIDTH-1:0] val);
    exp_q.push_back({dir, val});
    bus.dclk = 1'b1;
    repeat (h) @(negedge clk);
    bus.dclk = 1'b0;
    repeat (h) @(negedge clk);
  endtask

  task automatic flip_pulse();
    settle();
    bus.flip = 1'b1;
    @(negedge clk);
    bus.flip = 1'b0;
  endtask

  task automatic set_cfg(input logic en, input logic [WIDTH-1:0] lo,
                         input logic [WIDTH-1:0] hi);
    settle();
    bus.enable = en;
    bus.min    = lo;
    bus.max    = hi;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    bus.dclk   = 1'b0;
    bus.enable = 1'b0;
    bus.flip   = 1'b0;
    bus.min    = '0;
    bus.max    = '0;
    repeat (2) @(negedge clk);
    check("reset_out", {1'b0, bus.out}, {1'b0, 4'd0});
    check("reset_dir", {{(W-1){1'b0}}, bus.direction}, 5'd1);
    check("reset_tick", {{(W-1){1'b0}}, bus.tick}, 5'd0);
    rst = 1'b0;

    // bounce, dclk = clk/4
    set_cfg(1'b1, 4'd0, 4'd3);
    pulse(2, 1'b1, 4'd1);
    pulse(2, 1'b1, 4'd2);
    pulse(2, 1'b1, 4'd3);
    pulse(2, 1'b0, 4'd2);
    pulse(2, 1'b0, 4'd1);
    pulse(2, 1'b0, 4'd0);
    pulse(2, 1'b1, 4'd1);

    // flip at out = 2 while counting up
    pulse(2, 1'b1, 4'd2);
    flip_pulse();
    pulse(2, 1'b0, 4'd1);

    // two flips before one tick -> single reversal
    flip_pulse();
    flip_pulse();
    pulse(2, 1'b1, 4'd2);

    // flip at max while up
    pulse(2, 1'b1, 4'd3);
    flip_pulse();
    pulse(2, 1'b0, 4'd2);

    // enable low with flips pending; flip applies on first enabled step
    set_cfg(1'b0, 4'd0, 4'd3);
    pulse(2, 1'b0, 4'd2);
    flip_pulse();
    pulse(2, 1'b0, 4'd2);
    flip_pulse();
    pulse(2, 1'b0, 4'd2);
    set_cfg(1'b1, 4'd0, 4'd3);
    pulse(2, 1'b1, 4'd3);
    pulse(2, 1'b0, 4'd2);

    // invalid bounds
    set_cfg(1'b1, 4'd5, 4'd5);
    pulse(2, 1'b0, 4'd2);
    set_cfg(1'b1, 4'd4, 4'd9);
    pulse(2, 1'b0, 4'd2);
    set_cfg(1'b1, 4'd0, 4'd9);
    pulse(2, 1'b0, 4'd1);
    set_cfg(1'b1, 4'd9, 4'd3);
    pulse(2, 1'b0, 4'd1);

    // full width, dclk = clk/2
    set_cfg(1'b1, 4'd0, 4'd15);
    pulse(1, 1'b0, 4'd0);
    for (int v = 1; v <= 15; v++) begin
      pulse(1, 1'b1, 4'(v));
    end
    pulse(1, 1'b0, 4'd14);
    pulse(1, 1'b0, 4'd13);

    // asynchronous reset mid-count with a flip pending
    flip_pulse();
    settle();
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", {1'b0, bus.out}, {1'b0, 4'd0});
    check("async_rst_dir", {{(W-1){1'b0}}, bus.direction}, 5'd1);
    check("async_rst_tick", {{(W-1){1'b0}}, bus.tick}, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse(2, 1'b1, 4'd1);
    pulse(2, 1'b1, 4'd2);

    // drain: every queued expectation must have been met by a tick
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: actual=%0d entries left expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
